// File: rtl/button_step_conditioner_pkg.sv
// Shared front-panel I/O constants and types for the button step conditioner.
package button_step_conditioner_pkg;

  localparam int unsigned CLK_HZ              = 100_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = CLK_HZ / 2;    // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = CLK_HZ / 5;    // 200 ms
  localparam int unsigned STEP_COUNT_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } btn_state_t;

  // Bits needed to count 0 .. terminal-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned terminal);
    return (terminal <= 2) ? 1 : $clog2(terminal);
  endfunction

endpackage

// File: rtl/button_step_conditioner_sync_2ff.sv
// Generic two-flop synchronizer, asynchronous active-high reset to zero.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_step_conditioner.sv
// Debounces one raw push-button into a single-cycle step pulse, with optional
// auto-repeat while held, a debounced level and a wrapping pulse counter.
module button_step_conditioner
  import button_step_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_in,
  output logic                    pulse,
  output logic                    level,
  output logic [STEP_COUNT_W-1:0] step_count
);

  localparam int unsigned DEB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HOLD_W   = cnt_width(HOLD_MAX);

  localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  logic              btn_s;
  btn_state_t        state, state_next;
  logic [DEB_W-1:0]  deb_cnt, deb_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [HOLD_W-1:0] repeat_last;
  logic              repeating, repeating_next;
  logic              pulse_next, level_next;

  sync_2ff #(
    .WIDTH(1)
  ) u_sync (
    .clk(clk),
    .rst(reset),
    .d  (btn_in),
    .q  (btn_s)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      deb_cnt    <= '0;
      hold_cnt   <= '0;
      repeating  <= 1'b0;
      pulse      <= 1'b0;
      level      <= 1'b0;
      step_count <= '0;
    end else begin
      state     <= state_next;
      deb_cnt   <= deb_next;
      hold_cnt  <= hold_next;
      repeating <= repeating_next;
      pulse     <= pulse_next;
      level     <= level_next;
      if (pulse_next) begin
        step_count <= step_count + 1'b1;
      end
    end
  end

  // Debounce / hold / repeat decisions on the synchronized button.
  always_comb begin
    state_next     = state;
    deb_next       = deb_cnt;
    hold_next      = hold_cnt;
    repeating_next = repeating;
    pulse_next     = 1'b0;
    level_next     = level;
    repeat_last    = repeating ? PERIOD_LAST : DELAY_LAST;

    case (state)
      ST_IDLE: begin
        if (btn_s) begin
          state_next = ST_PRESS_WAIT;
          deb_next   = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_next = ST_IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_next     = ST_HELD;
          pulse_next     = 1'b1;
          level_next     = 1'b1;
          hold_next      = '0;
          repeating_next = 1'b0;
        end else begin
          deb_next = deb_cnt + 1'b1;
        end
      end

      ST_HELD: begin
        if (!btn_s) begin
          state_next = ST_RELEASE_WAIT;
          deb_next   = '0;
        end else if (REPEAT_EN) begin
          // hold_cnt parks at its terminal while pulse is still high, so a
          // repeat that lands right after another pulse slips one cycle
          // instead of producing back-to-back pulses.
          if (hold_cnt == repeat_last) begin
            if (!pulse) begin
              pulse_next     = 1'b1;
              hold_next      = '0;
              repeating_next = 1'b1;
            end
          end else begin
            hold_next = hold_cnt + 1'b1;
          end
        end
      end

      ST_RELEASE_WAIT: begin
        if (btn_s) begin
          state_next     = ST_HELD;
          hold_next      = '0;
          repeating_next = 1'b0;
        end else if (deb_cnt == DEB_LAST) begin
          state_next = ST_IDLE;
          level_next = 1'b0;
        end else begin
          deb_next = deb_cnt + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_button_step_conditioner.sv
// Scoreboard bench: a run-length/elapsed-time reference model predicts pulses,
// level and step count for a repeating and a non-repeating instance.
module tb_button_step_conditioner;

  localparam int unsigned D  = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn;
  logic        pulse_a, level_a, pulse_b, level_b;
  logic [15:0] sc_a, sc_b;
  logic        do_preset;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned run;    // consecutive samples disagreeing with level
    bit          level;
    int unsigned held;   // samples since the button (re)settled high
    bit          pulse;
    logic [15:0] cnt;
  } mdl_t;

  typedef struct {
    int unsigned cyc;
    logic [15:0] cnt;
  } exp_t;

  mdl_t ma, mb;
  exp_t qa[$];
  exp_t qb[$];
  bit   h1, h2;

  always #5 clk = ~clk;

  button_step_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_EN      (1'b1),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut_a (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn),
    .pulse     (pulse_a),
    .level     (level_a),
    .step_count(sc_a)
  );

  button_step_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_EN      (1'b0),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn),
    .pulse     (pulse_b),
    .level     (level_b),
    .step_count(sc_b)
  );

  function automatic mdl_t mclear();
    mdl_t m;
    m.run = 0; m.level = 1'b0; m.held = 0; m.pulse = 1'b0; m.cnt = '0;
    return m;
  endfunction

  // One clock of the behavioural model, given the synchronized sample b.
  function automatic mdl_t mstep(input mdl_t m_in, input bit b, input bit repen);
    mdl_t m = m_in;
    m.pulse = 1'b0;
    if (b != m.level) begin
      m.run++;
      if (m.run == D + 1) begin
        m.level = b;
        m.run   = 0;
        m.held  = 0;
        if (b) m.pulse = 1'b1;
      end
    end else begin
      if (b) begin
        if (m.run != 0) begin
          m.held = 0;
        end else begin
          m.held++;
          if (repen && m.held >= RD && ((m.held - RD) % RP) == 0) m.pulse = 1'b1;
        end
      end
      m.run = 0;
    end
    if (m.pulse) m.cnt++;
    return m;
  endfunction

  task automatic cmp(input string nm, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic hold_btn(input bit v, input int unsigned n);
    btn = v;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model and scoreboard push, in step with the DUT clock.
  initial begin
    ma = mclear(); mb = mclear(); h1 = 1'b0; h2 = 1'b0;
    forever begin
      @(posedge clk or posedge reset);
      cyc++;
      if (reset) begin
        ma = mclear(); mb = mclear(); h1 = 1'b0; h2 = 1'b0;
        qa.delete(); qb.delete();
      end else begin
        bit   b;
        exp_t e;
        b  = h2;
        h2 = h1;
        h1 = btn;
        ma = mstep(ma, b, 1'b1);
        mb = mstep(mb, b, 1'b0);
        if (do_preset) ma.cnt = 16'hFFFE;
        if (ma.pulse) begin e.cyc = cyc; e.cnt = ma.cnt; qa.push_back(e); end
        if (mb.pulse) begin e.cyc = cyc; e.cnt = mb.cnt; qb.push_back(e); end
      end
    end
  end

  // Monitor: pop an expected pulse whenever one is due or the DUT shows one.
  initial begin
    forever begin
      bit ea, eb;
      @(negedge clk);
      ea = (qa.size() > 0 && qa[0].cyc == cyc);
      eb = (qb.size() > 0 && qb[0].cyc == cyc);
      if (pulse_a || ea) cmp("a.pulse", pulse_a, ea);
      if (ea) begin cmp("a.step_count_at_pulse", sc_a, qa[0].cnt); void'(qa.pop_front()); end
      if (pulse_b || eb) cmp("b.pulse", pulse_b, eb);
      if (eb) begin cmp("b.step_count_at_pulse", sc_b, qb[0].cnt); void'(qb.pop_front()); end
      cmp("a.level", level_a, ma.level);
      cmp("a.step_count", sc_a, ma.cnt);
      cmp("b.level", level_b, mb.level);
      cmp("b.step_count", sc_b, mb.cnt);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    btn = 1'b0; reset = 1'b1; do_preset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    hold_btn(1'b0, 5);
    // clean press
    hold_btn(1'b1, 6);  hold_btn(1'b0, 15);
    // bounce shorter than the debounce window
    hold_btn(1'b1, 2);  hold_btn(1'b0, 1); hold_btn(1'b1, 2); hold_btn(1'b0, 15);
    // long hold with auto-repeat
    hold_btn(1'b1, 40); hold_btn(1'b0, 15);
    // release bounce while held
    hold_btn(1'b1, 20); hold_btn(1'b0, 2); hold_btn(1'b1, 20); hold_btn(1'b0, 15);
    // reset in the middle of a press, button kept high
    hold_btn(1'b1, 4);
    reset = 1'b1;
    hold_btn(1'b1, 2);
    reset = 1'b0;
    hold_btn(1'b1, 15); hold_btn(1'b0, 15);
    // random button activity
    for (int i = 0; i < 400; i++) begin
      hold_btn(1'($urandom_range(0, 1)), $urandom_range(1, (i % 10 == 0) ? 40 : 8));
    end
    hold_btn(1'b0, 15);
    // counter wrap: preload near 0xFFFF, then produce several pulses
    @(negedge clk);
    #1;
    force dut_a.step_count = 16'hFFFE;
    do_preset = 1'b1;
    @(posedge clk);
    #2;
    do_preset = 1'b0;
    release dut_a.step_count;
    hold_btn(1'b1, 30); hold_btn(1'b0, 15);
    cmp("a.pending", qa.size(), 0);
    cmp("b.pending", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
